// File: rtl/rs232_pkg.sv
// rs232_pkg
// Shared definitions for the RS232 receive framer: the FSM state encoding,
// oversampling constants, majority-vote sample positions, and small helpers
// for computing the tick divisor and the 2-of-3 vote.
package rs232_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_WAIT_HIGH
  } rx_state_t;

  localparam int OVERSAMPLE = 16;

  // Samples 7/8/9 straddle the bit centre; the vote resolves at sample 9.
  localparam logic [3:0] MAJ_A_IDX   = 4'd7;
  localparam logic [3:0] MAJ_B_IDX   = 4'd8;
  localparam logic [3:0] MAJ_C_IDX   = 4'd9;
  localparam logic [3:0] LAST_SAMPLE = 4'd15;
  localparam logic [2:0] LAST_BIT    = 3'd7;

  // Rounded clocks-per-tick for a 16x oversampled line.
  function automatic int calc_div(input int clk_hz, input int baud);
    return (clk_hz + (OVERSAMPLE / 2) * baud) / (OVERSAMPLE * baud);
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/rs232_tick_gen.sv
// rs232_tick_gen
// Free-running divider producing a one-cycle tick every P_DIV clocks.
// Ports:
//   clk  - logic clock
//   rst  - synchronous active-high reset
//   clr  - holds the count at zero; the first tick after clr drops comes
//          exactly P_DIV clocks later
//   tick - one-cycle pulse every P_DIV clocks
module rs232_tick_gen #(
  parameter int P_DIV = 27
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int            CW   = (P_DIV > 1) ? $clog2(P_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(P_DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || clr || tick) r_cnt <= '0;
    else                    r_cnt <= r_cnt + 1'b1;
  end

  assign tick = (r_cnt == LAST) && !clr;

endmodule

// File: rtl/rs232_rx_framer.sv
// rs232_rx_framer
// 8N1 RS232 receiver: 16x oversampling, 2-of-3 majority vote per bit, one
// write strobe per good byte into the receive FIFO, plus framing-error and
// overrun reporting.
// Ports:
//   clk           - logic clock
//   rst           - synchronous active-high reset
//   rx            - asynchronous serial input, idles high
//   rx_fifo_data  - last accepted byte, held until the next one
//   rx_fifo_wr_en - one-cycle FIFO write strobe
//   rx_fifo_full  - FIFO full, sampled in the stop-bit decision cycle
//   frame_err     - one-cycle pulse when the stop bit votes low
//   overrun_cnt   - bytes dropped on a full FIFO, saturating
//   busy          - high whenever the FSM is not idle
module rs232_rx_framer
  import rs232_pkg::*;
#(
  parameter int P_CLK_FREQ_HZ = 50000000,
  parameter int P_BAUD_RATE   = 115200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic [7:0]  rx_fifo_data,
  output logic        rx_fifo_wr_en,
  input  logic        rx_fifo_full,
  output logic        frame_err,
  output logic [15:0] overrun_cnt,
  output logic        busy
);

  localparam int DIV = calc_div(P_CLK_FREQ_HZ, P_BAUD_RATE);

  rx_state_t   r_state;
  logic        r_rx_m, r_rx_s;
  logic [1:0]  r_sync_vld;
  logic        r_armed;
  logic [3:0]  r_s;
  logic [2:0]  r_bit_idx;
  logic        r_smp_a, r_smp_b;
  logic [7:0]  r_shift;
  logic [7:0]  r_data;
  logic        r_wr_en;
  logic        r_frame_err;
  logic [15:0] r_overrun;
  logic        r_busy;

  logic w_tick, w_clr, w_maj, w_mid, w_end;

  // Two-flop synchronizer. The reset value of 1 is not a real observation
  // of the line, so r_sync_vld marks when r_rx_s reflects the pin; only then
  // may it arm the receiver.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_m     <= 1'b1;
      r_rx_s     <= 1'b1;
      r_sync_vld <= 2'b00;
    end else begin
      r_rx_m     <= rx;
      r_rx_s     <= r_rx_m;
      r_sync_vld <= {r_sync_vld[0], 1'b1};
    end
  end

  // Divider is parked while no frame is in progress, so entering START
  // restarts the bit timing from the detected edge.
  assign w_clr = (r_state == ST_IDLE) || (r_state == ST_WAIT_HIGH);

  rs232_tick_gen #(.P_DIV(DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (w_clr),
    .tick (w_tick)
  );

  assign w_maj = maj3(r_smp_a, r_smp_b, r_rx_s);
  assign w_mid = w_tick && (r_s == MAJ_C_IDX);
  assign w_end = w_tick && (r_s == LAST_SAMPLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_armed     <= 1'b0;
      r_s         <= '0;
      r_bit_idx   <= '0;
      r_smp_a     <= 1'b1;
      r_smp_b     <= 1'b1;
      r_shift     <= '0;
      r_data      <= '0;
      r_wr_en     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_wr_en     <= 1'b0;
      r_frame_err <= 1'b0;

      if (r_sync_vld[1] && r_rx_s) r_armed <= 1'b1;

      if (w_tick) begin
        r_s <= r_s + 4'd1;
        if (r_s == MAJ_A_IDX) r_smp_a <= r_rx_s;
        if (r_s == MAJ_B_IDX) r_smp_b <= r_rx_s;
      end

      case (r_state)
        ST_IDLE: begin
          if (r_armed && !r_rx_s) begin
            r_state <= ST_START;
            r_busy  <= 1'b1;
            r_s     <= '0;
          end
        end

        ST_START: begin
          if (w_mid && w_maj) begin
            // Start bit did not hold low through its centre: glitch.
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else if (w_end) begin
            r_state   <= ST_DATA;
            r_bit_idx <= '0;
          end
        end

        ST_DATA: begin
          if (w_mid) r_shift <= {w_maj, r_shift[7:1]};
          if (w_end) begin
            if (r_bit_idx == LAST_BIT) r_state <= ST_STOP;
            else                       r_bit_idx <= r_bit_idx + 3'd1;
          end
        end

        ST_STOP: begin
          // Decide at mid-stop so the back half of the stop bit is slack
          // for the next frame's start edge.
          if (w_mid) begin
            if (w_maj) begin
              if (!rx_fifo_full) begin
                r_data  <= r_shift;
                r_wr_en <= 1'b1;
              end else if (r_overrun != 16'hFFFF) begin
                r_overrun <= r_overrun + 16'd1;
              end
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= ST_WAIT_HIGH;
            end
          end
        end

        ST_WAIT_HIGH: begin
          // A break holds the line low; wait it out so it flags only once.
          if (r_rx_s) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign rx_fifo_data  = r_data;
  assign rx_fifo_wr_en = r_wr_en;
  assign frame_err     = r_frame_err;
  assign overrun_cnt   = r_overrun;
  assign busy          = r_busy;

endmodule

// File: tb/tb_rs232_rx_framer.sv
module tb_rs232_rx_framer;

  // 25 MHz keeps the run short; DIV = (25e6 + 8*115200) / (16*115200) = 14.
  localparam int CLK_HZ   = 25000000;
  localparam int BAUD     = 115200;
  localparam int DIV      = (CLK_HZ + 8 * BAUD) / (16 * BAUD);
  localparam int BIT_CLKS = 16 * DIV;
  localparam int LAT      = 2 + DIV * (9 * 16 + 10);
  localparam int BIT_FAST = (BIT_CLKS * 100) / 103;  // +3% baud
  localparam int BIT_SLOW = (BIT_CLKS * 100) / 97;   // -3% baud

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx  = 1'b0;
  logic        rx_fifo_full = 1'b0;
  logic [7:0]  rx_fifo_data;
  logic        rx_fifo_wr_en;
  logic        frame_err;
  logic [15:0] overrun_cnt;
  logic        busy;

  int n_pass = 0, n_total = 0;
  int cyc = 0, wr_cnt = 0, fe_cnt = 0, last_wr_cyc = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;

  rs232_rx_framer #(.P_CLK_FREQ_HZ(CLK_HZ), .P_BAUD_RATE(BAUD)) dut (
    .clk           (clk),
    .rst           (rst),
    .rx            (rx),
    .rx_fifo_data  (rx_fifo_data),
    .rx_fifo_wr_en (rx_fifo_wr_en),
    .rx_fifo_full  (rx_fifo_full),
    .frame_err     (frame_err),
    .overrun_cnt   (overrun_cnt),
    .busy          (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Scoreboard: every strobe must match the oldest expected byte.
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_err) fe_cnt++;
      if (rx_fifo_wr_en) begin
        wr_cnt++;
        last_wr_cyc = cyc;
        n_total++;
        if (exp_q.size() == 0) begin
          $display("FAIL sb_unexpected: strobe with data %02h, expected no strobe", rx_fifo_data);
        end else begin
          mon_exp = exp_q.pop_front();
          if (rx_fifo_data !== mon_exp)
            $display("FAIL sb_data: got %02h, expected %02h", rx_fifo_data, mon_exp);
          else if (frame_err !== 1'b0)
            $display("FAIL sb_excl: frame_err=%b with strobe, expected 0", frame_err);
          else
            n_pass++;
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int bclk, input logic stop_v);
    rx = 1'b0;
    repeat (bclk) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (bclk) @(negedge clk);
    end
    rx = stop_v;
    repeat (bclk) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx  = 1'b0;
    repeat (4) @(negedge clk);
    n_total++; if (rx_fifo_wr_en !== 1'b0) $display("FAIL rst_wr_en: got %b, expected 0", rx_fifo_wr_en); else n_pass++;
    n_total++; if (frame_err !== 1'b0) $display("FAIL rst_frame_err: got %b, expected 0", frame_err); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b, expected 0", busy); else n_pass++;
    n_total++; if (overrun_cnt !== 16'h0) $display("FAIL rst_overrun: got %04h, expected 0000", overrun_cnt); else n_pass++;
    n_total++; if (rx_fifo_data !== 8'h00) $display("FAIL rst_data: got %02h, expected 00", rx_fifo_data); else n_pass++;
    // Line held low through reset release must not start a frame.
    rst = 1'b0;
    repeat (3 * DIV) @(negedge clk);
    n_total++; if (busy !== 1'b0) $display("FAIL rst_low_line_busy: got %b, expected 0", busy); else n_pass++;
    rx = 1'b1;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic test_single_byte();
    int t0, w0, lat;
    @(negedge clk);
    w0 = wr_cnt;
    exp_q.push_back(8'h55);
    t0 = cyc;
    send_byte(8'h55, BIT_CLKS, 1'b1);
    n_total++; if (wr_cnt !== w0 + 1) $display("FAIL single_count: got %0d strobes, expected 1", wr_cnt - w0); else n_pass++;
    lat = last_wr_cyc - t0;
    n_total++;
    if (lat < LAT - 1 || lat > LAT + 1) $display("FAIL single_latency: got %0d cycles, expected %0d +-1", lat, LAT);
    else n_pass++;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int w0, f0;
    w0 = wr_cnt;
    f0 = fe_cnt;
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(8'(i));
      send_byte(8'(i), BIT_CLKS, 1'b1);
    end
    repeat (2 * BIT_CLKS) @(negedge clk);
    n_total++; if (wr_cnt !== w0 + 16) $display("FAIL b2b_count: got %0d strobes, expected 16", wr_cnt - w0); else n_pass++;
    n_total++; if (fe_cnt !== f0) $display("FAIL b2b_frame_err: got %0d pulses, expected 0", fe_cnt - f0); else n_pass++;
    n_total++; if (exp_q.size() != 0) $display("FAIL b2b_pending: %0d bytes not received, expected 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_overrun();
    int w0;
    w0 = wr_cnt;
    n_total++; if (overrun_cnt !== 16'd0) $display("FAIL ovr_before: got %0d, expected 0", overrun_cnt); else n_pass++;
    rx_fifo_full = 1'b1;
    send_byte(8'hA3, BIT_CLKS, 1'b1);
    repeat (BIT_CLKS) @(negedge clk);
    rx_fifo_full = 1'b0;
    n_total++; if (overrun_cnt !== 16'd1) $display("FAIL ovr_after: got %0d, expected 1", overrun_cnt); else n_pass++;
    n_total++; if (wr_cnt !== w0) $display("FAIL ovr_strobe: got %0d strobes, expected 0", wr_cnt - w0); else n_pass++;
    n_total++; if (rx_fifo_data !== 8'h0F) $display("FAIL ovr_data_held: got %02h, expected 0f", rx_fifo_data); else n_pass++;
  endtask

  task automatic test_frame_err();
    int w0, f0;
    w0 = wr_cnt;
    f0 = fe_cnt;
    send_byte(8'h33, BIT_CLKS, 1'b0);
    rx = 1'b0;
    repeat (3 * BIT_CLKS) @(negedge clk);
    rx = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);
    n_total++; if (fe_cnt !== f0 + 1) $display("FAIL fe_count: got %0d pulses, expected 1", fe_cnt - f0); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL fe_busy: got %b, expected 0", busy); else n_pass++;
    exp_q.push_back(8'h7E);
    send_byte(8'h7E, BIT_CLKS, 1'b1);
    repeat (BIT_CLKS) @(negedge clk);
    n_total++; if (wr_cnt !== w0 + 1) $display("FAIL fe_recover: got %0d strobes, expected 1", wr_cnt - w0); else n_pass++;
  endtask

  task automatic test_glitch();
    int w0, f0;
    w0 = wr_cnt;
    f0 = fe_cnt;
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (6) @(negedge clk);
    n_total++; if (busy !== 1'b1) $display("FAIL glitch_start: busy=%b, expected 1", busy); else n_pass++;
    repeat (2 * BIT_CLKS) @(negedge clk);
    n_total++; if (busy !== 1'b0) $display("FAIL glitch_idle: busy=%b, expected 0", busy); else n_pass++;
    n_total++;
    if (wr_cnt !== w0 || fe_cnt !== f0)
      $display("FAIL glitch_flags: strobes %0d frame_err %0d, expected 0 and 0", wr_cnt - w0, fe_cnt - f0);
    else n_pass++;
  endtask

  task automatic test_reset_midframe();
    int w0;
    w0 = wr_cnt;
    fork
      send_byte(8'hC3, BIT_CLKS, 1'b1);
      begin
        repeat (5 * BIT_CLKS + BIT_CLKS / 2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_total++; if (rx_fifo_wr_en !== 1'b0) $display("FAIL rstmid_wr_en: got %b, expected 0", rx_fifo_wr_en); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL rstmid_busy_in_rst: got %b, expected 0", busy); else n_pass++;
        rst = 1'b0;
      end
    join
    repeat (BIT_CLKS) @(negedge clk);
    n_total++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b, expected 0", busy); else n_pass++;
    n_total++; if (wr_cnt !== w0) $display("FAIL rstmid_strobe: got %0d strobes, expected 0", wr_cnt - w0); else n_pass++;
    n_total++; if (overrun_cnt !== 16'd0) $display("FAIL rstmid_overrun: got %0d, expected 0", overrun_cnt); else n_pass++;
    exp_q.push_back(8'h11);
    send_byte(8'h11, BIT_CLKS, 1'b1);
    repeat (BIT_CLKS) @(negedge clk);
    n_total++; if (wr_cnt !== w0 + 1) $display("FAIL rstmid_next: got %0d strobes, expected 1", wr_cnt - w0); else n_pass++;
  endtask

  task automatic test_tolerance();
    int w0;
    w0 = wr_cnt;
    exp_q.push_back(8'h5A);
    send_byte(8'h5A, BIT_FAST, 1'b1);
    repeat (BIT_CLKS) @(negedge clk);
    n_total++; if (wr_cnt !== w0 + 1) $display("FAIL tol_fast: got %0d strobes, expected 1", wr_cnt - w0); else n_pass++;
    exp_q.push_back(8'h5A);
    send_byte(8'h5A, BIT_SLOW, 1'b1);
    repeat (BIT_CLKS) @(negedge clk);
    n_total++; if (wr_cnt !== w0 + 2) $display("FAIL tol_slow: got %0d strobes, expected 2", wr_cnt - w0); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_overrun();
    test_frame_err();
    test_glitch();
    test_reset_midframe();
    test_tolerance();
    n_total++;
    if (exp_q.size() != 0) $display("FAIL sb_drain: %0d bytes never received, expected 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
